// File: rtl/y86_mem_pkg.sv
// Shared types for the Y86 unified memory port arbiter.
package y86_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Requesting side of the memory port.
  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } mem_side_t;

  // Default cycle budget for a memory acknowledge.
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that flags when an access has waited its full
// budget. expired is high during the TIMEOUT-th enabled cycle after a clear.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Count enabled cycles; clear wins, and the count holds at MAX instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access.
// Round-robin on ties, one outstanding access, sticky timeout error.
//
// Handshake: a requester raises x_req with stable address/data and holds it
// until its xMemReady pulse; the port raises mem_req for the whole access and
// the memory answers with a single-cycle mem_ack carrying mem_rdata. One
// RELEASE cycle follows every access so a requester can drop x_req before
// the next arbitration.
module mem_port_arbiter
  import y86_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              IMemReady,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              DMemReady,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err,
  output arb_state_t        dbgState,
  output mem_side_t         dbgLastGrant
);

  arb_state_t state;
  arb_state_t nextState;
  mem_side_t  lastGrant;

  logic startAccess;
  logic grantD;
  logic finish;
  logic timedOut;
  logic ctrClear;
  logic ctrEnable;
  logic expired;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctrClear),
    .enable (ctrEnable),
    .expired(expired)
  );

  // Next-state and control decode: arbitration in IDLE, ack/timeout in BUSY.
  always_comb begin
    nextState   = state;
    startAccess = 1'b0;
    grantD      = 1'b0;
    finish      = 1'b0;
    timedOut    = 1'b0;
    ctrClear    = 1'b1;
    ctrEnable   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          startAccess = 1'b1;
          // D wins when alone, or on a tie when I was granted last.
          grantD      = d_req && (!i_req || (lastGrant == SIDE_I));
          nextState   = grantD ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        ctrClear  = 1'b0;
        ctrEnable = 1'b1;
        // An ack in the expiry cycle still counts as a normal completion.
        if (mem_ack) begin
          finish = 1'b1;
        end else if (expired) begin
          finish   = 1'b1;
          timedOut = 1'b1;
        end
        if (finish) begin
          nextState = RELEASE;
        end
      end
      RELEASE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Memory-side request registers, requester responses and grant history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      IMemReady <= 1'b0;
      DMemReady <= 1'b0;
      mem_err   <= 1'b0;
      lastGrant <= SIDE_I;
    end else begin
      IMemReady <= 1'b0;
      DMemReady <= 1'b0;
      if (startAccess) begin
        mem_req <= 1'b1;
        if (grantD) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          lastGrant <= SIDE_D;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
          lastGrant <= SIDE_I;
        end
      end
      if (finish) begin
        mem_req <= 1'b0;
        if (timedOut) begin
          mem_err <= 1'b1;
        end
        if (state == BUSY_I) begin
          IMemReady <= 1'b1;
          i_rdata   <= timedOut ? '0 : mem_rdata;
        end else begin
          DMemReady <= 1'b1;
          // A completed write leaves the last read word in place.
          if (timedOut) begin
            d_rdata <= '0;
          end else if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign dbgState     = state;
  assign dbgLastGrant = lastGrant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized
// back-to-back run against a behavioural round-robin/memory model.
module tb_mem_port_arbiter;
  import y86_mem_pkg::*;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [63:0] i_rdata;
  logic        IMemReady;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        DMemReady;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  arb_state_t  dbgState;
  mem_side_t   dbgLastGrant;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          mLast;
  logic [63:0] expI;
  logic [63:0] expD;
  logic        expErr;
  logic [17:0] exp_q[$];

  typedef struct {
    int          side;
    int          busy;
    int          waitN;
    logic [15:0] addr;
    logic        we;
    logic [63:0] wdata;
    int          iPulses;
    int          dPulses;
    logic [63:0] iData;
    logic [63:0] dData;
    bit          stable;
    bit          reqLowAtEnd;
    bit          relState;
    bit          hung;
  } obs_t;

  mem_port_arbiter #(
    .ADDR_W (16),
    .DATA_W (64),
    .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .IMemReady   (IMemReady),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .DMemReady   (DMemReady),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err),
    .dbgState    (dbgState),
    .dbgLastGrant(dbgLastGrant)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    mLast  = 0;
    expI   = '0;
    expD   = '0;
    expErr = 1'b0;
  endfunction

  // Round-robin rule: single requester wins; on a tie the side not granted last.
  function automatic int model_pick(bit iq, bit dq);
    if (iq && dq) return (mLast == 0) ? 1 : 0;
    return dq ? 1 : 0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Memory responder: called at a negedge with requests already set. Acks in
  // BUSY cycle ackAt (0-based, -1 = never), returns at the IDLE negedge.
  task automatic serve(input int ackAt, input logic [63:0] rd, input bit dropMid, output obs_t o);
    int n;
    o.side = -1; o.busy = 0; o.waitN = 0; o.addr = '0; o.we = 1'b0; o.wdata = '0;
    o.iPulses = 0; o.dPulses = 0; o.iData = '0; o.dData = '0;
    o.stable = 1'b1; o.reqLowAtEnd = 1'b0; o.relState = 1'b0; o.hung = 1'b0;
    while (!mem_req && o.waitN < 10) begin
      @(negedge clk);
      o.waitN++;
    end
    if (!mem_req) begin
      o.hung = 1'b1;
      return;
    end
    o.side  = (dbgState == BUSY_D) ? 1 : 0;
    o.addr  = mem_addr;
    o.we    = mem_we;
    o.wdata = mem_wdata;
    n = 0;
    while ((dbgState == BUSY_I || dbgState == BUSY_D) && n < 40) begin
      o.busy++;
      n++;
      if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata || mem_req !== 1'b1)
        o.stable = 1'b0;
      o.iPulses += int'(IMemReady);
      o.dPulses += int'(DMemReady);
      if (dropMid && o.busy == 1) begin
        if (o.side == 1) d_req = 1'b0; else i_req = 1'b0;
      end
      if (o.busy - 1 == ackAt) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (n >= 40) o.hung = 1'b1;
    o.reqLowAtEnd = !mem_req;
    o.relState    = (dbgState == RELEASE);
    o.iPulses += int'(IMemReady);
    o.dPulses += int'(DMemReady);
    o.iData = i_rdata;
    o.dData = d_rdata;
    @(negedge clk);
    o.iPulses += int'(IMemReady);
    o.dPulses += int'(DMemReady);
  endtask

  task automatic test_reset();
    checks++; if (dbgState !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_mem: req=%0b we=%0b addr=%0h wdata=%0h expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (i_rdata !== 64'h0 || d_rdata !== 64'h0 || IMemReady !== 1'b0 || DMemReady !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_resp: irdata=%0h drdata=%0h ir=%0b dr=%0b err=%0b expected all 0", i_rdata, d_rdata, IMemReady, DMemReady, mem_err); end
    checks++; if (dbgLastGrant !== SIDE_I) begin errors++; $display("FAIL reset_last_grant: got %0d expected %0d", dbgLastGrant, SIDE_I); end
  endtask

  task automatic test_fetch();
    obs_t o;
    logic [63:0] w;
    w = 64'h30F2_0A00_0000_0000;
    i_req = 1'b1; i_addr = 16'h0010;
    mLast = model_pick(1'b1, 1'b0);
    serve(2, w, 1'b0, o);
    i_req = 1'b0;
    expI = w;
    checks++; if (o.hung || o.side !== 0 || o.addr !== 16'h0010 || o.we !== 1'b0) begin
      errors++; $display("FAIL fetch_request: side=%0d addr=%0h we=%0b hung=%0b expected side 0 addr 10 we 0", o.side, o.addr, o.we, o.hung); end
    checks++; if (o.busy !== 3 || !o.stable) begin errors++; $display("FAIL fetch_busy: busy=%0d stable=%0b expected 3/1", o.busy, o.stable); end
    checks++; if (o.iPulses !== 1 || o.dPulses !== 0) begin errors++; $display("FAIL fetch_ready: i=%0d d=%0d expected 1/0", o.iPulses, o.dPulses); end
    checks++; if (o.iData !== expI) begin errors++; $display("FAIL fetch_rdata: got %0h expected %0h", o.iData, expI); end
    checks++; if (!o.reqLowAtEnd || !o.relState) begin errors++; $display("FAIL fetch_release: reqlow=%0b release=%0b expected 1/1", o.reqLowAtEnd, o.relState); end
  endtask

  task automatic test_data_write();
    obs_t o;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 64'h0000_0000_DEAD_BEEF;
    mLast = model_pick(1'b0, 1'b1);
    serve(0, 64'h1111_2222_3333_4444, 1'b0, o);
    d_req = 1'b0; d_we = 1'b0;
    checks++; if (o.hung || o.side !== 1 || o.addr !== 16'h0100 || o.we !== 1'b1 || o.wdata !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL write_request: side=%0d addr=%0h we=%0b wdata=%0h expected 1/100/1/deadbeef", o.side, o.addr, o.we, o.wdata); end
    checks++; if (o.dPulses !== 1 || o.iPulses !== 0 || o.busy !== 1) begin
      errors++; $display("FAIL write_ready: d=%0d i=%0d busy=%0d expected 1/0/1", o.dPulses, o.iPulses, o.busy); end
    checks++; if (o.dData !== expD) begin errors++; $display("FAIL write_rdata_kept: got %0h expected %0h", o.dData, expD); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    int exp;
    apply_reset();
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      logic [63:0] rd;
      rd = {$urandom, $urandom};
      exp = model_pick(1'b1, 1'b1);
      mLast = exp;
      serve(0, rd, 1'b0, o);
      if (exp == 1) expD = rd; else expI = rd;
      checks++; if (o.hung || o.side !== exp) begin errors++; $display("FAIL tie_grant_%0d: got %0d expected %0d", k, o.side, exp); end
      checks++; if (o.waitN !== 1 || !o.relState) begin errors++; $display("FAIL tie_turnaround_%0d: wait=%0d release=%0b expected 1/1", k, o.waitN, o.relState); end
      checks++; if (int'(dbgLastGrant) !== mLast) begin errors++; $display("FAIL tie_last_grant_%0d: got %0d expected %0d", k, dbgLastGrant, mLast); end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++; if (i_rdata !== expI || d_rdata !== expD) begin
      errors++; $display("FAIL tie_rdata: i=%0h d=%0h expected %0h %0h", i_rdata, d_rdata, expI, expD); end
  endtask

  task automatic test_ack_timeout_and_stray();
    obs_t o;
    logic [63:0] rd;
    // Stray ack while idle.
    mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || IMemReady !== 1'b0 || DMemReady !== 1'b0 || dbgState !== IDLE) begin
      errors++; $display("FAIL stray_ack: req=%0b ir=%0b dr=%0b state=%0d expected 0/0/0/IDLE", mem_req, IMemReady, DMemReady, dbgState); end
    checks++; if (i_rdata !== expI || d_rdata !== expD || mem_err !== 1'b0) begin
      errors++; $display("FAIL stray_ack_data: i=%0h d=%0h err=%0b expected %0h %0h 0", i_rdata, d_rdata, mem_err, expI, expD); end
    // Ack in the very cycle the budget runs out.
    rd = 64'h0123_4567_89AB_CDEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    mLast = model_pick(1'b0, 1'b1);
    serve(TMO - 1, rd, 1'b0, o);
    d_req = 1'b0;
    expD = rd;
    checks++; if (o.hung || o.busy !== TMO || o.dPulses !== 1 || o.iPulses !== 0) begin
      errors++; $display("FAIL ack_at_limit_ready: busy=%0d d=%0d i=%0d expected %0d/1/0", o.busy, o.dPulses, o.iPulses, TMO); end
    checks++; if (mem_err !== 1'b0 || o.dData !== expD) begin
      errors++; $display("FAIL ack_at_limit_err: err=%0b rdata=%0h expected 0 %0h", mem_err, o.dData, expD); end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [63:0] rd;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
    mLast = model_pick(1'b0, 1'b1);
    serve(-1, 64'h0, 1'b0, o);
    d_req = 1'b0;
    expD = '0; expErr = 1'b1;
    checks++; if (o.hung || o.busy !== TMO || o.dPulses !== 1) begin
      errors++; $display("FAIL timeout_ready: busy=%0d d=%0d hung=%0b expected %0d/1/0", o.busy, o.dPulses, o.hung, TMO); end
    checks++; if (o.dData !== expD || mem_err !== expErr) begin
      errors++; $display("FAIL timeout_err: rdata=%0h err=%0b expected 0 1", o.dData, mem_err); end
    rd = {$urandom, $urandom};
    i_req = 1'b1; i_addr = 16'h0600;
    mLast = model_pick(1'b1, 1'b0);
    serve(0, rd, 1'b0, o);
    i_req = 1'b0;
    expI = rd;
    checks++; if (mem_err !== expErr || o.iData !== expI || o.iPulses !== 1) begin
      errors++; $display("FAIL timeout_sticky: err=%0b rdata=%0h pulses=%0d expected 1 %0h 1", mem_err, o.iData, o.iPulses, expI); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    logic [63:0] rd;
    i_req = 1'b1; i_addr = 16'h0044;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || dbgState !== BUSY_I) begin
      errors++; $display("FAIL midreset_busy: req=%0b state=%0d expected 1 BUSY_I", mem_req, dbgState); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || dbgState !== IDLE) begin
      errors++; $display("FAIL midreset_async: req=%0b state=%0d expected 0 IDLE", mem_req, dbgState); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 64'h0 || i_rdata !== 64'h0 || d_rdata !== 64'h0 || mem_err !== 1'b0 || IMemReady !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: we=%0b addr=%0h irdata=%0h drdata=%0h err=%0b expected all 0", mem_we, mem_addr, i_rdata, d_rdata, mem_err); end
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    rd = {$urandom, $urandom};
    i_req = 1'b1; i_addr = 16'h0020;
    mLast = model_pick(1'b1, 1'b0);
    serve(1, rd, 1'b0, o);
    i_req = 1'b0;
    expI = rd;
    checks++; if (o.hung || o.side !== 0 || o.addr !== 16'h0020 || o.iData !== expI || o.iPulses !== 1 || o.busy !== 2) begin
      errors++; $display("FAIL midreset_recover: side=%0d addr=%0h rdata=%0h pulses=%0d busy=%0d", o.side, o.addr, o.iData, o.iPulses, o.busy); end
  endtask

  task automatic test_back_to_back_random();
    obs_t o;
    for (int k = 0; k < 40; k++) begin
      int side, ackAt, expBusy;
      bit tmo, drop;
      logic [63:0] rd;
      logic [17:0] expv, obsv;
      if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = 16'($urandom); end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 16'($urandom); d_wdata = {$urandom, $urandom};
      end
      if (!i_req && !d_req) begin i_req = 1'b1; i_addr = 16'($urandom); end
      side  = model_pick(i_req, d_req);
      mLast = side;
      exp_q.push_back({side[0], (side == 1) ? d_addr : i_addr, (side == 1) ? d_we : 1'b0});
      ackAt = $urandom_range(0, 9);
      rd    = {$urandom, $urandom};
      drop  = ($urandom_range(0, 3) == 0);
      tmo   = (ackAt >= TMO);
      expBusy = tmo ? TMO : ackAt + 1;
      if (side == 1) begin
        if (tmo) expD = '0; else if (!d_we) expD = rd;
      end else begin
        expI = tmo ? 64'h0 : rd;
      end
      expErr = expErr | tmo;
      serve(ackAt, rd, drop, o);
      expv = exp_q.pop_front();
      obsv = {(o.side == 1), o.addr, o.we};
      checks++; if (o.hung || obsv !== expv) begin
        errors++; $display("FAIL rand_grant_%0d: got %0h expected %0h hung=%0b", k, obsv, expv, o.hung); end
      checks++; if (o.busy !== expBusy || !o.stable || o.iPulses !== (side == 0 ? 1 : 0) || o.dPulses !== (side == 1 ? 1 : 0)) begin
        errors++; $display("FAIL rand_timing_%0d: busy=%0d stable=%0b i=%0d d=%0d expected busy %0d side %0d", k, o.busy, o.stable, o.iPulses, o.dPulses, expBusy, side); end
      checks++; if (o.iData !== expI || o.dData !== expD || mem_err !== expErr) begin
        errors++; $display("FAIL rand_data_%0d: i=%0h d=%0h err=%0b expected %0h %0h %0b", k, o.iData, o.dData, mem_err, expI, expD, expErr); end
      if (side == 1) d_req = 1'b0; else i_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_data_write();
    test_simultaneous();
    test_ack_timeout_and_stray();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
